// File: rtl/tick_timer_if.sv
// tick_timer_if
//   Groups the control inputs and status outputs of tick_timer so that a
//   controller can connect to the timer through one port.
//
//   Signals
//     load        controller -> timer  one-cycle strobe, captures load_value
//     load_value  controller -> timer  countdown start value, unsigned
//     start       controller -> timer  level-sampled start/resume request
//     pause       controller -> timer  level-sampled pause request
//     count       timer -> controller  remaining tick count
//     running     timer -> controller  timer is counting down
//     paused      timer -> controller  timer is frozen
//     expired     timer -> controller  countdown reached zero
//     done        timer -> controller  one-cycle pulse on expiry
//
//   Modports
//     master  the controller side (drives the requests)
//     slave   the timer side (drives the status)
`timescale 1ns/1ps
interface tick_timer_if #(
    parameter int WIDTH = 16
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             paused;
    logic             expired;
    logic             done;

    modport master (
        output load,
        output load_value,
        output start,
        output pause,
        input  count,
        input  running,
        input  paused,
        input  expired,
        input  done
    );

    modport slave (
        input  load,
        input  load_value,
        input  start,
        input  pause,
        output count,
        output running,
        output paused,
        output expired,
        output done
    );
endinterface

// File: rtl/tick_timer.sv
// tick_timer
//   Countdown timer paced by an externally divided 10 kHz square wave.
//   The square wave is treated as data: it is synchronized into the
//   clock1M domain and each rising edge produces a one-cycle tick that
//   decrements the count while the timer is running.
//
//   Ports
//     clock1M    in   system clock (1 MHz), all flops on its rising edge
//     reset      in   asynchronous active-high reset
//     clk_10KHz  in   10 kHz square wave, sampled as data
//     bus        slave modport of tick_timer_if (load/start/pause in,
//                count/running/paused/expired/done out)
//
//   Behaviour summary
//     load (any state) copies load_value into both the count and the
//     reload register; a zero value parks the timer in IDLE.
//     Per-cycle priority: load > pause > start > tick.
//     Expiry drives count to 0, enters DONE and pulses done for one cycle.
//     From DONE a start restarts the countdown from the reload value.
`timescale 1ns/1ps
module tick_timer #(
    parameter int WIDTH = 16
) (
    input  logic         clock1M,
    input  logic         reset,
    input  logic         clk_10KHz,
    tick_timer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADED  = 3'd1,
        S_RUNNING = 3'd2,
        S_PAUSED  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] COUNT_ZERO = '0;

    // ------------------------------------------------------------------
    // Tick generation
    //   sync_reg[0] = s1, sync_reg[1] = s2 (two-flop synchronizer)
    //   sync_reg[2] = s3 (history of s2 for rising-edge detection)
    // With all three cleared by reset, a square wave that is already high
    // when reset is released still produces a tick only after it has
    // propagated through s1/s2, never from stale state.
    // ------------------------------------------------------------------
    logic [2:0] sync_reg;
    logic       tick;

    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], clk_10KHz};
        end
    end

    assign tick = sync_reg[1] & ~sync_reg[2];

    // ------------------------------------------------------------------
    // Control state and datapath registers
    // ------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic             done_reg;
    logic             done_next;
    logic             running_reg;
    logic             paused_reg;
    logic             expired_reg;

    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            count_reg  <= COUNT_ZERO;
            reload_reg <= COUNT_ZERO;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
        end
    end

    // Status outputs are registered copies of the next state, so they
    // line up with state_reg and are glitch-free at the module boundary.
    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            done_reg    <= 1'b0;
            running_reg <= 1'b0;
            paused_reg  <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            done_reg    <= done_next;
            running_reg <= (state_next == S_RUNNING);
            paused_reg  <= (state_next == S_PAUSED);
            expired_reg <= (state_next == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        done_next   = 1'b0;

        if (bus.load) begin
            // Load wins over everything, including a coincident tick.
            reload_next = bus.load_value;
            count_next  = bus.load_value;
            state_next  = (bus.load_value != COUNT_ZERO) ? S_LOADED : S_IDLE;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    // Nothing to count: start is ignored until a load.
                end

                S_LOADED: begin
                    // Pause outranks start; with no paused count to
                    // freeze, a pause here simply holds LOADED.
                    if (!bus.pause && bus.start) begin
                        state_next = S_RUNNING;
                    end
                end

                S_RUNNING: begin
                    if (bus.pause) begin
                        state_next = S_PAUSED;
                    end else if (tick) begin
                        if (count_reg == COUNT_ONE) begin
                            count_next = COUNT_ZERO;
                            state_next = S_DONE;
                            done_next  = 1'b1;
                        end else if (count_reg != COUNT_ZERO) begin
                            count_next = count_reg - COUNT_ONE;
                        end
                        // A zero count while running holds at zero
                        // rather than wrapping.
                    end
                end

                S_PAUSED: begin
                    if (bus.start && !bus.pause) begin
                        state_next = S_RUNNING;
                    end
                end

                S_DONE: begin
                    // Restart from the last loaded value; pause has no
                    // meaning once the countdown has finished.
                    if (bus.start) begin
                        count_next = reload_reg;
                        state_next = S_RUNNING;
                    end
                end

                default: begin
                    state_next = S_IDLE;
                    count_next = COUNT_ZERO;
                end
            endcase
        end
    end

    assign bus.count   = count_reg;
    assign bus.done    = done_reg;
    assign bus.running = running_reg;
    assign bus.paused  = paused_reg;
    assign bus.expired = expired_reg;

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer
//   Self-checking bench for tick_timer. A behavioural model tracks the
//   timer from the sampled inputs each clock; every cycle the DUT outputs
//   are compared with the model, and directed scenarios add explicit
//   checks on spacing, latency, collisions, restart and reset.
`timescale 1ns/1ps
module tb_tick_timer;
    localparam int WIDTH = 16;

    logic clock1M   = 1'b0;
    logic reset     = 1'b0;
    logic clk_10KHz = 1'b0;

    tick_timer_if #(.WIDTH(WIDTH)) bus ();

    tick_timer #(.WIDTH(WIDTH)) dut (
        .clock1M   (clock1M),
        .reset     (reset),
        .clk_10KHz (clk_10KHz),
        .bus       (bus)
    );

    always #500 clock1M = ~clock1M;

    // ---------------- bookkeeping ----------------
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int phase    = 0;
    bit auto_clk = 1'b1;
    int prev_cnt = 0;
    int dut_done_cnt = 0;
    int dec_q[$];

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_LOADED, M_RUNNING, M_PAUSED, M_DONE} mstate_t;
    mstate_t m_state;
    int      m_count;
    int      m_reload;
    bit      m_done;
    bit      h0, h1, h2;   // clk_10KHz samples taken at the last three edges

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_count  = 0;
        m_reload = 0;
        m_done   = 1'b0;
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    endtask

    // A rising edge of the square wave seen at edge k-2 (high there, low at
    // k-3) is acted on at edge k.
    task automatic model_update(input bit ld, input int lv, input bit st,
                                input bit ps, input bit c10, input bit rs);
        bit tk;
        if (rs) begin
            model_reset();
            return;
        end
        tk = h1 && !h2;
        h2 = h1; h1 = h0; h0 = c10;
        m_done = 1'b0;
        if (ld) begin
            m_reload = lv;
            m_count  = lv;
            m_state  = (lv != 0) ? M_LOADED : M_IDLE;
        end else begin
            case (m_state)
                M_LOADED:  if (st && !ps) m_state = M_RUNNING;
                M_RUNNING: begin
                    if (ps) m_state = M_PAUSED;
                    else if (tk) begin
                        if (m_count == 1) begin
                            m_count = 0;
                            m_state = M_DONE;
                            m_done  = 1'b1;
                        end else if (m_count > 1) begin
                            m_count = m_count - 1;
                        end
                    end
                end
                M_PAUSED:  if (st && !ps) m_state = M_RUNNING;
                M_DONE:    if (st) begin
                    m_count = m_reload;
                    m_state = M_RUNNING;
                end
                default: ;
            endcase
        end
    endtask

    // One clock: sample the inputs, advance model at the edge, compare 1 ns later.
    task automatic step(input string tag);
        bit ld, st, ps, c10, rs;
        int lv;
        if (auto_clk) clk_10KHz = ((phase % 100) < 50);
        phase++;
        ld = bus.load; lv = int'(bus.load_value); st = bus.start; ps = bus.pause;
        c10 = clk_10KHz; rs = reset;
        @(posedge clock1M);
        model_update(ld, lv, st, ps, c10, rs);
        #1;
        cyc++;
        check({tag, "_count"},   32'(bus.count), 32'(m_count));
        check({tag, "_running"}, 32'(bus.running), 32'(m_state == M_RUNNING));
        check({tag, "_paused"},  32'(bus.paused),  32'(m_state == M_PAUSED));
        check({tag, "_expired"}, 32'(bus.expired), 32'(m_state == M_DONE));
        check({tag, "_done"},    32'(bus.done),    32'(m_done));
        if (int'(bus.count) < prev_cnt) dec_q.push_back(cyc);
        prev_cnt = int'(bus.count);
        if (bus.done) dut_done_cnt++;
    endtask

    task automatic do_load(input int v);
        bus.load = 1'b1; bus.load_value = WIDTH'(v);
        step("load");
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step("start");
        bus.start = 1'b0;
    endtask

    // Absolute watchdog so the run can never hang.
    initial begin
        #60ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        bus.load = 1'b0; bus.load_value = '0; bus.start = 1'b0; bus.pause = 1'b0;
        model_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("reset");
        #300 reset = 1'b0;
        for (int i = 0; i < 5; i++) step("idle");

        // ---- basic countdown from 3 at 10 kHz ----
        do_load(3);
        do_start();
        dec_q.delete();
        dut_done_cnt = 0;
        reached = 0;
        for (int i = 0; i < 600 && !reached; i++) begin
            step("cd3");
            if (m_state == M_DONE) reached = 1;
        end
        for (int i = 0; i < 5; i++) step("cd3_hold");
        check("cd3_reached", 32'(reached), 1);
        check("cd3_decrements", dec_q.size(), 3);
        if (dec_q.size() == 3) begin
            check("cd3_spacing_a", dec_q[1] - dec_q[0], 100);
            check("cd3_spacing_b", dec_q[2] - dec_q[1], 100);
        end
        check("cd3_done_pulses", dut_done_cnt, 1);
        check("cd3_expired", 32'(bus.expired), 1);
        check("cd3_final", 32'(bus.count), 0);

        // ---- tick latency with manually placed rising edge ----
        auto_clk = 1'b0;
        clk_10KHz = 1'b0;
        do_load(5);
        do_start();
        for (int i = 0; i < 4; i++) step("lat_pre");
        check("lat_pre_count", 32'(bus.count), 5);
        #998 clk_10KHz = 1'b1;            // 1 ns before edge E0
        step("lat_e0");
        check("lat_e0_count", 32'(bus.count), 5);
        step("lat_e1");
        check("lat_e1_count", 32'(bus.count), 5);
        step("lat_e2");
        check("lat_e2_count", 32'(bus.count), 4);
        for (int i = 0; i < 4; i++) step("lat_post");
        check("lat_post_count", 32'(bus.count), 4);
        clk_10KHz = 1'b0;
        auto_clk = 1'b1;
        phase = 0;

        // ---- pause / resume ----
        do_load(10);
        do_start();
        reached = 0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            step("pr_run");
            if (m_count == 6) reached = 1;
        end
        check("pr_reached6", 32'(reached), 1);
        bus.pause = 1'b1;
        for (int i = 0; i < 500; i++) step("pr_pause");
        check("pr_pause_count", 32'(bus.count), 6);
        check("pr_pause_flag", 32'(bus.paused), 1);
        bus.pause = 1'b0;
        do_start();
        dec_q.delete();
        reached = 0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            step("pr_resume");
            if (m_state == M_DONE) reached = 1;
        end
        check("pr_done_reached", 32'(reached), 1);
        check("pr_resume_decrements", dec_q.size(), 6);
        check("pr_final", 32'(bus.count), 0);

        // ---- load colliding with a tick, start+pause in PAUSED ----
        do_load(7);
        do_start();
        reached = 0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            step("col_run");
            if (m_count == 2 && m_state == M_RUNNING) reached = 1;
        end
        check("col_reached2", 32'(reached), 1);
        reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (h1 && !h2) reached = 1;
            else step("col_wait");
        end
        check("col_tick_found", 32'(reached), 1);
        dut_done_cnt = 0;
        do_load(7);
        check("col_count", 32'(bus.count), 7);
        check("col_running", 32'(bus.running), 0);
        check("col_no_done", dut_done_cnt, 0);
        do_start();
        for (int i = 0; i < 3; i++) step("col_run2");
        bus.pause = 1'b1;
        step("col_pause");
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) step("col_sp");
        check("col_sp_paused", 32'(bus.paused), 1);
        bus.start = 1'b0; bus.pause = 1'b0;

        // ---- restart from DONE, then zero load ----
        do_load(4);
        do_start();
        reached = 0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            step("rs_run");
            if (m_state == M_DONE) reached = 1;
        end
        check("rs_done_reached", 32'(reached), 1);
        step("rs_hold");
        do_start();
        check("rs_count", 32'(bus.count), 4);
        check("rs_running", 32'(bus.running), 1);
        dut_done_cnt = 0;
        do_load(0);
        check("z_count", 32'(bus.count), 0);
        check("z_running", 32'(bus.running), 0);
        do_start();
        for (int i = 0; i < 250; i++) step("z_idle");
        check("z_idle_count", 32'(bus.count), 0);
        check("z_no_done", dut_done_cnt, 0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            bus.load       = ($urandom % 40) == 0;
            bus.load_value = WIDTH'($urandom % 6);
            bus.start      = ($urandom % 8) == 0;
            bus.pause      = ($urandom % 20) == 0;
            step("rnd");
        end
        bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;

        // ---- asynchronous reset mid-RUNNING ----
        do_load(12);
        do_start();
        reached = 0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            step("ar_run");
            if (m_count == 9 && m_state == M_RUNNING) reached = 1;
        end
        check("ar_reached9", 32'(reached), 1);
        dut_done_cnt = 0;
        #400 reset = 1'b1;
        #1;
        check("ar_async_count",   32'(bus.count), 0);
        check("ar_async_running", 32'(bus.running), 0);
        check("ar_async_paused",  32'(bus.paused), 0);
        check("ar_async_expired", 32'(bus.expired), 0);
        check("ar_async_done",    32'(bus.done), 0);
        model_reset();
        bus.start = 1'b1;
        bus.load  = 1'b1; bus.load_value = WIDTH'(5);   // ignored under reset
        for (int i = 0; i < 3; i++) step("ar_held");
        bus.load = 1'b0;
        #300 reset = 1'b0;
        for (int i = 0; i < 250; i++) step("ar_after");
        bus.start = 1'b0;
        check("ar_after_count", 32'(bus.count), 0);
        check("ar_after_running", 32'(bus.running), 0);
        check("ar_no_done", dut_done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter: WIDTH, default 16, bit width of the countdown value.
REQ-002 clock1M  input  1  system clock, 1 MHz; every flop in the block is clocked on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high; takes effect immediately, independent of clock1M.
REQ-004 clk_10KHz  input  1  divided 10 kHz square wave from the clock divider, sampled here as data, not used as a clock.
REQ-005 load  input  1  when high for one cycle, captures load_value.
REQ-006 load_value  input  WIDTH  countdown start value, unsigned.
REQ-007 start  input  1  level-sampled start/resume request.
REQ-008 pause  input  1  level-sampled pause request.
REQ-009 count  output  WIDTH  current remaining tick count.
REQ-010 running  output  1  high only in the RUNNING state.
REQ-011 paused  output  1  high only in the PAUSED state.
REQ-012 expired  output  1  high only in the DONE state.
REQ-013 done  output  1  one-cycle pulse on expiry.

Function
REQ-014 clk_10KHz shall pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-015 Internal tick = s2 AND NOT s3; exactly one tick per clk_10KHz period, one clock1M cycle wide.
REQ-016 Tick latency: clk_10KHz first sampled high at edge E0 -> tick high after E1 -> count updates at E2.
REQ-017 States: IDLE, LOADED, RUNNING, PAUSED, DONE; all state registers are updated only on a clock1M edge or by reset.
REQ-018 load, any state: reload_reg <= load_value; count <= load_value; next state is LOADED if load_value != 0, otherwise IDLE.
REQ-019 Priority per cycle: load > pause > start > tick.
REQ-020 A tick in the same cycle as load is discarded, with no decrement.
REQ-021 IDLE: start is ignored; count holds.
REQ-022 LOADED: start -> RUNNING; tick ignored.
REQ-023 RUNNING: on each tick, count <= count - 1.
REQ-024 RUNNING: a tick with count == 1 sets count <= 0, enters DONE and asserts done for exactly that next cycle.
REQ-025 RUNNING: pause -> PAUSED; a tick in the same cycle is discarded.
REQ-026 PAUSED: count frozen and ticks ignored; start without pause -> RUNNING; start with pause stays in PAUSED.
REQ-027 DONE: count stays 0 and expired is high.
REQ-028 DONE: start -> RUNNING with count <= reload_reg (restart); pause is ignored.
REQ-029 count never wraps below 0; a decrement from 0 is unreachable by construction, and count shall hold 0 if ever reached.
REQ-030 done shall never assert for two consecutive cycles.
REQ-031 done, running, paused and expired are registered outputs; at most one of running, paused and expired is high at any time.
REQ-032 Loading 0 shall never produce a done pulse.

Reset
REQ-033 Asserting reset shall clear, asynchronously: s1, s2, s3, count, reload_reg, done, running, paused and expired to 0; state to IDLE.
REQ-034 While reset is high, all inputs are ignored.
REQ-035 After reset deassertion, the first tick is not generated until clk_10KHz is seen rising through the synchronizer (s3 starts at 0).
REQ-036 Reset mid-RUNNING shall abort the count with no done pulse.
REQ-037 Reset mid-PAUSED shall likewise abort with no done pulse; restart after any reset requires a new load.

Verification
REQ-038 load=1 with load_value=3, then start, with clk_10KHz at 10 kHz: count goes 3->2->1->0 at 100 us spacing; done is high one cycle; expired stays high; exactly 3 decrements.
REQ-039 Tick latency: clk_10KHz rises 1 ns before edge E0 in RUNNING with count=5 -> count=4 exactly at E2, not earlier or later.
REQ-040 Pause/resume: value 10, run 4 ticks, assert pause for 500 us (5 ticks), then start -> count holds 6 during the pause and reaches 0 after 6 further ticks.
REQ-041 Collisions: load(7) in the same cycle as a tick while RUNNING with count=2 -> count=7, state LOADED, no done; start and pause together in PAUSED -> remains PAUSED.
REQ-042 DONE restart and zero load: from DONE after load 4, start -> count=4 and running=1; load_value=0 with load -> IDLE, count=0, and start is ignored.
REQ-043 Reset: assert reset asynchronously mid-RUNNING with count=9, between clock edges -> all outputs 0 before the next edge; no done pulse; start after release has no effect until a new load.
